// File: rtl/perf_control_interface_pkg.sv
// Shared constants for the performance-counter control front end:
// register addresses, CONTROL field positions and the data word type.
package perf_control_interface_pkg;

  typedef logic [31:0] scalar_t;

  localparam int TOTAL_PERF_EVENTS = 16;
  localparam int SEL_WIDTH         = 4;

  localparam logic [1:0] PERF_REG_SELECT  = 2'd0;
  localparam logic [1:0] PERF_REG_CONTROL = 2'd1;
  localparam logic [1:0] PERF_REG_VALUE   = 2'd2;
  localparam logic [1:0] PERF_REG_STATUS  = 2'd3;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_EVENT_LSB  = 8;

endpackage

// File: rtl/perf_control_interface_if.sv
// Control-register bus between the core's CR unit and the perf front end.
interface perf_control_interface_if;
  import perf_control_interface_pkg::*;

  // Strobe bus with no back-pressure: a write or read is taken in the cycle its
  // enable is high; read data arrives with cr_read_valid exactly one cycle later.
  logic       cr_write_en;
  logic       cr_read_en;
  logic [1:0] cr_addr;
  scalar_t    cr_write_data;
  scalar_t    cr_read_data;
  logic       cr_read_valid;

  modport master (
    output cr_write_en, cr_read_en, cr_addr, cr_write_data,
    input  cr_read_data, cr_read_valid
  );

  modport slave (
    input  cr_write_en, cr_read_en, cr_addr, cr_write_data,
    output cr_read_data, cr_read_valid
  );
endinterface

// File: rtl/perf_counter_slot.sv
// Per-counter control state: enable, irq enable, event select, sticky
// overflow and the one-cycle clear pulse.
module perf_counter_slot
  import perf_control_interface_pkg::*;
#(
  parameter int EVENT_IDX_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ctrl_write,
  input  scalar_t                    write_data,
  input  logic                       status_clear,
  input  logic                       wrap,
  output logic                       enable,
  output logic                       irq_en,
  output logic [EVENT_IDX_WIDTH-1:0] event_sel,
  output logic                       overflow,
  output logic                       clear
);

  logic clear_req;
  assign clear_req = ctrl_write & write_data[CTRL_CLEAR_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      event_sel <= '0;
      overflow  <= 1'b0;
      clear     <= 1'b0;
    end else begin
      if (ctrl_write) begin
        enable    <= write_data[CTRL_ENABLE_BIT];
        irq_en    <= write_data[CTRL_IRQ_EN_BIT];
        event_sel <= write_data[CTRL_EVENT_LSB +: EVENT_IDX_WIDTH];
      end
      clear <= clear_req;
      // A wrap in the same cycle as any clear keeps the overflow visible.
      if (wrap) begin
        overflow <= 1'b1;
      end else if (clear_req || status_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/perf_control_interface.sv
// Performance-counter control front end: counter select, address decode,
// registered read port and the overflow interrupt.
module perf_control_interface
  import perf_control_interface_pkg::*;
#(
  parameter int NUM_COUNTERS    = 4,
  parameter int NUM_EVENTS      = TOTAL_PERF_EVENTS,
  parameter int COUNTER_WIDTH   = 32,
  parameter int EVENT_IDX_WIDTH = $clog2(NUM_EVENTS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  perf_control_interface_if.slave                 cr,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]   counter_value,
  input  logic [NUM_COUNTERS-1:0]                 counter_wrap,
  output logic [NUM_COUNTERS-1:0]                 counter_enable,
  output logic [NUM_COUNTERS-1:0]                 counter_clear,
  output logic [NUM_COUNTERS*EVENT_IDX_WIDTH-1:0] counter_event_sel,
  output logic                                    perf_interrupt
);

  logic [SEL_WIDTH-1:0]       sel;
  logic                       wr_select;
  logic                       wr_control;
  logic                       wr_status;
  logic [NUM_COUNTERS-1:0]    irq_en_v;
  logic [NUM_COUNTERS-1:0]    overflow_v;
  logic [EVENT_IDX_WIDTH-1:0] event_a [NUM_COUNTERS];
  scalar_t                    read_next;
  scalar_t                    read_data_q;
  logic                       read_valid_q;

  assign wr_select  = cr.cr_write_en && (cr.cr_addr == PERF_REG_SELECT);
  assign wr_control = cr.cr_write_en && (cr.cr_addr == PERF_REG_CONTROL);
  assign wr_status  = cr.cr_write_en && (cr.cr_addr == PERF_REG_STATUS);

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_slot
    perf_counter_slot #(
      .EVENT_IDX_WIDTH(EVENT_IDX_WIDTH)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .ctrl_write  (wr_control && (sel == SEL_WIDTH'(g))),
      .write_data  (cr.cr_write_data),
      .status_clear(wr_status && cr.cr_write_data[g]),
      .wrap        (counter_wrap[g]),
      .enable      (counter_enable[g]),
      .irq_en      (irq_en_v[g]),
      .event_sel   (event_a[g]),
      .overflow    (overflow_v[g]),
      .clear       (counter_clear[g])
    );
    assign counter_event_sel[g*EVENT_IDX_WIDTH +: EVENT_IDX_WIDTH] = event_a[g];
  end

  // Read mux sees pre-write state, so a same-cycle write is not reflected.
  always_comb begin
    read_next = '0;
    case (cr.cr_addr)
      PERF_REG_SELECT: read_next[SEL_WIDTH-1:0] = sel;
      PERF_REG_CONTROL: begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          if (sel == SEL_WIDTH'(i)) begin
            read_next[CTRL_ENABLE_BIT] = counter_enable[i];
            read_next[CTRL_IRQ_EN_BIT] = irq_en_v[i];
            read_next[CTRL_EVENT_LSB +: EVENT_IDX_WIDTH] = event_a[i];
          end
        end
      end
      PERF_REG_VALUE: begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          if (sel == SEL_WIDTH'(i)) begin
            read_next[COUNTER_WIDTH-1:0] = counter_value[i*COUNTER_WIDTH +: COUNTER_WIDTH];
          end
        end
      end
      default: read_next[NUM_COUNTERS-1:0] = overflow_v;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel            <= '0;
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      perf_interrupt <= 1'b0;
    end else begin
      // Out-of-range selects are dropped so sel always names a real counter.
      if (wr_select && ({1'b0, cr.cr_write_data[SEL_WIDTH-1:0]} < (SEL_WIDTH+1)'(NUM_COUNTERS))) begin
        sel <= cr.cr_write_data[SEL_WIDTH-1:0];
      end
      read_valid_q <= cr.cr_read_en;
      if (cr.cr_read_en) begin
        read_data_q <= read_next;
      end
      perf_interrupt <= |(overflow_v & irq_en_v);
    end
  end

  assign cr.cr_read_data  = read_data_q;
  assign cr.cr_read_valid = read_valid_q;

endmodule

// File: doc/perf_control_interface.md
# perf_control_interface

Control-register front end for the performance counters. It decodes control-register reads and writes into per-counter enable, event-select and clear controls, and returns counter values through a registered read port. It also tracks counter wrap-around in sticky overflow bits that drive a maskable interrupt. It sits between the core's control register unit and the array of performance counters, which consumes its control outputs and returns values and wrap pulses.

## Interface
Parameters:
- NUM_COUNTERS, 4, number of counters managed (1..16)
- NUM_EVENTS, `TOTAL_PERF_EVENTS, number of selectable events
- COUNTER_WIDTH, 32, counter value width (≤32)
- EVENT_IDX_WIDTH, $clog2(NUM_EVENTS), event selector width

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- cr_write_en  in  1  register write strobe
- cr_read_en  in  1  register read strobe
- cr_addr  in  2  register select: 0 SELECT, 1 CONTROL, 2 VALUE, 3 STATUS
- cr_write_data  in  32  write data (scalar_t)
- cr_read_data  out  32  read data, registered
- cr_read_valid  out  1  read data valid pulse
- counter_value  in  NUM_COUNTERS×COUNTER_WIDTH  current counter values
- counter_wrap  in  NUM_COUNTERS  one-cycle pulse when a counter wraps to 0
- counter_enable  out  NUM_COUNTERS  counting enable per counter
- counter_clear  out  NUM_COUNTERS  one-cycle synchronous clear pulse
- counter_event_sel  out  NUM_COUNTERS×EVENT_IDX_WIDTH  event index per counter
- perf_interrupt  out  1  overflow interrupt, level

## Operation
- SELECT (addr 0)
  - Write: bits[3:0] become current index `sel` if < NUM_COUNTERS; otherwise the write is ignored and `sel` is unchanged.
  - Read: returns `sel`, zero-extended.
- CONTROL (addr 1), acts on counter `sel`.
  - Write bit0: enable.
  - Write bit1: clear. Emits a counter_clear[sel] pulse and clears overflow[sel].
  - Write bit2: interrupt enable.
  - Write bits[8 +: EVENT_IDX_WIDTH]: event select.
  - Read: returns {event_sel, irq_en, 1'b0, enable} in the same positions; bit1 always reads 0.
- VALUE (addr 2): read returns counter_value[sel], zero-extended. Writes are ignored.
- STATUS (addr 3)
  - Read: bits[NUM_COUNTERS-1:0] are the sticky overflow bits.
  - Write: write-1-to-clear.
- counter_wrap[i] sets overflow[i].
- Simultaneous wrap and clear (W1C or CONTROL clear) on the same counter: set wins.
- Reads return pre-write state when a read and a write occur in the same cycle.
- perf_interrupt = OR over i of (overflow[i] & irq_en[i]), registered.
- Reset values:
  - sel = 0.
  - All enable, irq_en, event_sel and overflow = 0.
  - counter_clear = 0, cr_read_data = 0, cr_read_valid = 0, perf_interrupt = 0.

## Timing
- Read latency is 1 cycle: cr_read_en in cycle N gives cr_read_valid=1 and data in cycle N+1. Back-to-back reads are accepted every cycle.
- Write effects:
  - Register state updates at the edge ending the write cycle.
  - counter_enable and counter_event_sel change at that edge, i.e. visible in cycle N+1.
  - counter_clear is high for exactly cycle N+1.
- A write to SELECT in cycle N retargets a CONTROL or VALUE access in cycle N+1.
- Wrap pulse in cycle N:
  - overflow is set in N+1.
  - perf_interrupt rises in N+2 if irq_en is set.
- perf_interrupt falls 2 cycles after the last enabled overflow bit is cleared.
- Reset asserted mid-operation forces all outputs to their reset values immediately. Any in-flight read or clear is dropped.

## Structure
- Shared package holds:
  - register address constants (PERF_REG_SELECT/CONTROL/VALUE/STATUS)
  - CONTROL bit positions (enable, clear, irq_en, event field LSB = 8)
- Sub-module perf_counter_slot, generated NUM_COUNTERS times. Each slot holds enable, irq_en, event_sel and overflow, plus the clear pulse flop, for one counter.
- The top level holds `sel`, address decode, the read mux/register and the interrupt OR/flop.

## Test plan
- Reset release: all outputs 0. Reading STATUS gives cr_read_valid one cycle later with data 0.
- Write SELECT=2, then CONTROL=0x0000_0305 (event 3, irq_en, enable) → counter_enable=4'b0100 and counter_event_sel[2]=3 in the next cycle. Reading CONTROL returns 0x305.
- Write SELECT=7 with NUM_COUNTERS=4 → read SELECT still returns 2.
- Set counter_value[2]=0xDEAD_BEEF and read VALUE → 0xDEAD_BEEF one cycle after the strobe.
- Pulse counter_wrap[2] → STATUS reads 0x4 and perf_interrupt=1 two cycles after the pulse. Write STATUS=0x4 in the same cycle as a new wrap[2] → bit stays set. A later W1C alone → perf_interrupt drops two cycles later.
- CONTROL write with bit1=1 on sel=1 → counter_clear=4'b0010 for exactly one cycle and overflow[1] cleared. Assert reset during that pulse → counter_clear drops immediately.
